// File: rtl/ir_rx_pkg.sv
// Shared constants for the NEC IR receiver: register map, CTRL/CLEAR bits,
// 10 us tick-count thresholds and decoder state encoding.
package ir_rx_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_CLEAR  = 2'd3;

   localparam int unsigned CTRL_ENABLE = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;
   localparam int unsigned CTRL_CHK_EN = 2;
   localparam logic [2:0]  CTRL_RESET  = 3'b101;

   localparam int unsigned CLR_FLUSH = 0;
   localparam int unsigned CLR_OVF   = 1;
   localparam int unsigned CLR_ERR   = 2;

   localparam int unsigned DUR_W = 11;

   // Durations in 10 us ticks
   localparam logic [DUR_W-1:0] LEAD_LO_MIN = 11'd800;
   localparam logic [DUR_W-1:0] LEAD_LO_MAX = 11'd1000;
   localparam logic [DUR_W-1:0] LEAD_HI_MIN = 11'd400;
   localparam logic [DUR_W-1:0] LEAD_HI_MAX = 11'd500;
   localparam logic [DUR_W-1:0] RPT_HI_MIN  = 11'd200;
   localparam logic [DUR_W-1:0] RPT_HI_MAX  = 11'd250;
   localparam logic [DUR_W-1:0] MARK_MIN    = 11'd40;
   localparam logic [DUR_W-1:0] MARK_MAX    = 11'd70;
   localparam logic [DUR_W-1:0] SPC0_MIN    = 11'd40;
   localparam logic [DUR_W-1:0] SPC0_MAX    = 11'd70;
   localparam logic [DUR_W-1:0] SPC1_MIN    = 11'd140;
   localparam logic [DUR_W-1:0] SPC1_MAX    = 11'd190;
   localparam logic [DUR_W-1:0] TIMEOUT     = 11'd1200;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD_LO,
      S_LEAD_HI,
      S_BIT_LO,
      S_BIT_HI
   } dec_state_t;

   function automatic logic in_range(input logic [DUR_W-1:0] v,
                                     input logic [DUR_W-1:0] lo,
                                     input logic [DUR_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ir_nec_decoder.sv
// NEC pulse-distance decoder: input synchroniser, 10 us tick, duration
// counter, frame FSM and LSB-first shift register.
module ir_nec_decoder
   import ir_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000
)
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_rxd,
   output logic        o_frame_valid,
   output logic        o_is_repeat,
   output logic [31:0] o_code,
   output logic        o_busy
);

   localparam int unsigned DIV   = (CLK_HZ / 100_000 > 0) ? CLK_HZ / 100_000 : 1;
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic             r_meta, r_sync, r_sync_d;
   logic             w_fall, w_rise, w_tick;
   logic [DIV_W-1:0] r_div;
   logic [DUR_W-1:0] r_dur;
   dec_state_t       r_state, w_state_nxt;
   logic [31:0]      r_shift, w_shift_nxt;
   logic [4:0]       r_bitcnt, w_bitcnt_nxt;
   logic             w_frame_valid, w_is_repeat;
   logic             w_sp0, w_sp1;

   // Line idles high, so the synchroniser resets to 1 to avoid a false fall
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b1;
         r_sync   <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_meta   <= i_rxd;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign w_fall = r_sync_d & ~r_sync;
   assign w_rise = ~r_sync_d & r_sync;
   assign w_tick = (r_div == DIV_W'(DIV - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div <= '0;
         r_dur <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         if (w_fall || w_rise)
            r_dur <= '0;
         else if (w_tick && (r_dur != '1))
            r_dur <= r_dur + DUR_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_bitcnt <= w_bitcnt_nxt;
      end
   end

   assign w_sp0 = in_range(r_dur, SPC0_MIN, SPC0_MAX);
   assign w_sp1 = in_range(r_dur, SPC1_MIN, SPC1_MAX);

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bitcnt_nxt  = r_bitcnt;
      w_frame_valid = 1'b0;
      w_is_repeat   = 1'b0;
      if (!i_enable) begin
         w_state_nxt = S_IDLE;
      end else if ((r_state != S_IDLE) && (r_dur >= TIMEOUT)) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fall) w_state_nxt = S_LEAD_LO;
            end
            S_LEAD_LO: begin
               if (w_rise)
                  w_state_nxt = in_range(r_dur, LEAD_LO_MIN, LEAD_LO_MAX) ? S_LEAD_HI : S_IDLE;
            end
            S_LEAD_HI: begin
               if (w_fall) begin
                  w_state_nxt = S_IDLE;
                  if (in_range(r_dur, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                     w_state_nxt  = S_BIT_LO;
                     w_bitcnt_nxt = '0;
                  end else if (in_range(r_dur, RPT_HI_MIN, RPT_HI_MAX)) begin
                     w_frame_valid = 1'b1;
                     w_is_repeat   = 1'b1;
                  end
               end
            end
            S_BIT_LO: begin
               if (w_rise)
                  w_state_nxt = in_range(r_dur, MARK_MIN, MARK_MAX) ? S_BIT_HI : S_IDLE;
            end
            S_BIT_HI: begin
               if (w_fall) begin
                  w_state_nxt = S_IDLE;
                  if (w_sp0 || w_sp1) begin
                     w_shift_nxt = {w_sp1, r_shift[31:1]};
                     if (r_bitcnt == 5'd31) begin
                        w_frame_valid = 1'b1;
                     end else begin
                        w_state_nxt  = S_BIT_LO;
                        w_bitcnt_nxt = r_bitcnt + 5'd1;
                     end
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame strobe is combinational so the FIFO write lands on the decode edge
   assign o_frame_valid = w_frame_valid;
   assign o_is_repeat   = w_is_repeat;
   assign o_code        = w_shift_nxt;
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: rtl/ir_rx_avalon.sv
// NEC IR receiver with Avalon-MM slave, code FIFO and level interrupt.
// Define IR_RX_REPEAT_EN to turn repeat frames into FIFO entries.
module ir_rx_avalon
   import ir_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned FIFO_DEPTH = 8
)
(
   input  logic        csi_clk,
   input  logic        csi_reset_n,
   input  logic        avs_chipselect,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic        ins_irq,
   input  logic        coe_IRDA_RXD,
   output logic        coe_busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic        w_frame_valid, w_is_repeat, w_busy;
   logic [31:0] w_code;

   logic [2:0]  r_ctrl;
   logic [32:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic        r_ovf;
   logic [7:0]  r_err;
   logic        r_irq;
   logic [31:0] r_rdata;

   logic        w_wr, w_rd, w_empty, w_full;
   logic        w_flush, w_clr_ovf, w_clr_err;
   logic        w_chk_ok, w_frame_ok, w_chk_err;
   logic        w_rpt_push, w_push_req, w_push, w_pop, w_ovf_set;
   logic [32:0] w_push_data, w_head;
   logic [7:0]  w_level;
   logic [31:0] w_status;
   logic        w_unused;

   ir_nec_decoder #(.CLK_HZ(CLK_HZ)) u_dec (
      .i_clk         (csi_clk),
      .i_rst_n       (csi_reset_n),
      .i_enable      (r_ctrl[CTRL_ENABLE]),
      .i_rxd         (coe_IRDA_RXD),
      .o_frame_valid (w_frame_valid),
      .o_is_repeat   (w_is_repeat),
      .o_code        (w_code),
      .o_busy        (w_busy)
   );

   assign w_wr      = avs_chipselect & avs_write;
   assign w_rd      = avs_chipselect & avs_read;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_flush   = w_wr && (avs_address == ADDR_CLEAR) && avs_writedata[CLR_FLUSH];
   assign w_clr_ovf = w_wr && (avs_address == ADDR_CLEAR) && avs_writedata[CLR_OVF];
   assign w_clr_err = w_wr && (avs_address == ADDR_CLEAR) && avs_writedata[CLR_ERR];

   assign w_chk_ok   = (w_code[23:16] == ~w_code[31:24]);
   assign w_frame_ok = w_frame_valid & ~w_is_repeat & (~r_ctrl[CTRL_CHK_EN] | w_chk_ok);
   assign w_chk_err  = w_frame_valid & ~w_is_repeat & r_ctrl[CTRL_CHK_EN] & ~w_chk_ok;

`ifdef IR_RX_REPEAT_EN
   logic [31:0] r_last_code;
   logic        r_last_vld;

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         r_last_code <= '0;
         r_last_vld  <= 1'b0;
      end else if (w_frame_ok) begin
         r_last_code <= w_code;
         r_last_vld  <= 1'b1;
      end
   end

   assign w_rpt_push  = w_frame_valid & w_is_repeat & r_last_vld;
   assign w_push_data = w_is_repeat ? {1'b1, r_last_code} : {1'b0, w_code};
`else
   assign w_rpt_push  = 1'b0;
   assign w_push_data = {1'b0, w_code};
`endif

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign w_push_req = w_frame_ok | w_rpt_push;
   assign w_pop      = w_rd && (avs_address == ADDR_DATA) && !w_empty;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;

   assign w_head   = r_mem[r_rptr];
   assign w_level  = 8'(r_count);
   assign w_status = {8'h00, r_err, w_level, 3'b000, w_busy,
                      w_head[32] & ~w_empty, r_ovf, w_full, w_empty};
   assign w_unused = ^avs_writedata[31:3];

   always_ff @(posedge csi_clk) begin
      if (w_push && !w_flush)
         r_mem[r_wptr] <= w_push_data;
   end

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         r_ctrl  <= CTRL_RESET;
         r_ovf   <= 1'b0;
         r_err   <= '0;
         r_irq   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_wr && (avs_address == ADDR_CTRL))
            r_ctrl <= avs_writedata[2:0];

         if (w_clr_ovf)      r_ovf <= 1'b0;
         else if (w_ovf_set) r_ovf <= 1'b1;

         if (w_clr_err)                        r_err <= '0;
         else if (w_chk_err && (r_err != '1))  r_err <= r_err + 8'd1;

         r_irq <= r_ctrl[CTRL_IRQ_EN] & ~w_empty;

         if (w_rd) begin
            case (avs_address)
               ADDR_DATA:   r_rdata <= w_empty ? '0 : w_head[31:0];
               ADDR_STATUS: r_rdata <= w_status;
               ADDR_CTRL:   r_rdata <= {29'd0, r_ctrl};
               default:     r_rdata <= '0;
            endcase
         end
      end
   end

   assign avs_readdata = r_rdata;
   assign ins_irq      = r_irq;
   assign coe_busy     = w_busy;

endmodule

// File: tb/tb_ir_rx_avalon.sv
// Directed bench for ir_rx_avalon; CLK_HZ is set so one tick equals one clock.
`timescale 1ns/1ps
module tb_ir_rx_avalon;

   localparam int unsigned CLK_HZ     = 100_000;
   localparam int unsigned FIFO_DEPTH = 8;

   logic        csi_clk;
   logic        csi_reset_n;
   logic        avs_chipselect;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        ins_irq;
   logic        coe_IRDA_RXD;
   logic        coe_busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   ir_rx_avalon #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .csi_clk        (csi_clk),
      .csi_reset_n    (csi_reset_n),
      .avs_chipselect (avs_chipselect),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_readdata   (avs_readdata),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .ins_irq        (ins_irq),
      .coe_IRDA_RXD   (coe_IRDA_RXD),
      .coe_busy       (coe_busy)
   );

   initial csi_clk = 1'b0;
   always #5 csi_clk = ~csi_clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] data;
      string       name;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = addr; avs_writedata = data;
      @(negedge csi_clk);
      avs_chipselect = 1'b0; avs_write = 1'b0; avs_writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = addr;
      @(negedge csi_clk);
      avs_chipselect = 1'b0; avs_read = 1'b0;
      data = avs_readdata;
   endtask

   task automatic read_check(input logic [1:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] d;
      bus_read(addr, d);
      check(name, d, exp);
   endtask

   task automatic ir_hold(input logic lvl, input int unsigned n);
      coe_IRDA_RXD = lvl;
      repeat (n) @(negedge csi_clk);
   endtask

   task automatic send_bits(input logic [31:0] code, input int unsigned nbits);
      for (int unsigned i = 0; i < nbits; i++) begin
         ir_hold(1'b0, 43);
         ir_hold(1'b1, code[i] ? 143 : 43);
      end
   endtask

   // With pop set, a DATA read is issued in the cycle whose closing edge pushes the frame
   task automatic send_frame(input logic [31:0] code, input bit pop, output logic [31:0] popped);
      popped = '0;
      ir_hold(1'b0, 803);
      ir_hold(1'b1, 403);
      send_bits(code, 32);
      coe_IRDA_RXD = 1'b0;
      @(negedge csi_clk);
      @(negedge csi_clk);
      if (pop) bus_read(2'd0, popped);
      else     @(negedge csi_clk);
      ir_hold(1'b0, 40);
      ir_hold(1'b1, 10);
   endtask

   task automatic send_repeat();
      ir_hold(1'b0, 803);
      ir_hold(1'b1, 203);
      ir_hold(1'b0, 43);
      ir_hold(1'b1, 10);
   endtask

   logic [31:0] rd;

   initial begin
      tbl[0]  = '{0, 2'd1, 32'h0000_0001, "rst_status"};
      tbl[1]  = '{0, 2'd2, 32'h0000_0005, "rst_ctrl"};
      tbl[2]  = '{0, 2'd0, 32'h0000_0000, "rst_data_empty"};
      tbl[3]  = '{0, 2'd3, 32'h0000_0000, "rst_addr3"};
      tbl[4]  = '{1, 2'd1, 32'hFFFF_FFFF, ""};
      tbl[5]  = '{1, 2'd0, 32'hFFFF_FFFF, ""};
      tbl[6]  = '{0, 2'd1, 32'h0000_0001, "ro_status"};
      tbl[7]  = '{1, 2'd2, 32'hFFFF_FFF2, ""};
      tbl[8]  = '{0, 2'd2, 32'h0000_0002, "ctrl_rw"};
      tbl[9]  = '{0, 2'd3, 32'h0000_0000, "addr3_read"};
      tbl[10] = '{1, 2'd2, 32'h0000_0007, ""};
      tbl[11] = '{0, 2'd2, 32'h0000_0007, "ctrl_all"};

      csi_reset_n = 1'b0; avs_chipselect = 1'b0; avs_address = '0; avs_read = 1'b0;
      avs_write = 1'b0; avs_writedata = '0; coe_IRDA_RXD = 1'b1;
      repeat (3) @(negedge csi_clk);
      check("rst_readdata", avs_readdata, 32'h0);
      check("rst_irq", {31'd0, ins_irq}, 32'h0);
      check("rst_busy", {31'd0, coe_busy}, 32'h0);
      csi_reset_n = 1'b1;
      repeat (3) @(negedge csi_clk);

      for (int unsigned i = 0; i < 12; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
         else           read_check(tbl[i].addr, tbl[i].data, tbl[i].name);
      end

      // Valid frame with checksum enforced
      send_frame(32'h00FF_A25D, 1'b0, rd);
      read_check(2'd1, 32'h0000_0100, "valid_status");
      check("valid_irq", {31'd0, ins_irq}, 32'h1);
      read_check(2'd0, 32'h00FF_A25D, "valid_data");
      @(negedge csi_clk);
      check("valid_irq_low", {31'd0, ins_irq}, 32'h0);
      read_check(2'd1, 32'h0000_0001, "valid_empty");

      // Bad checksum dropped and counted
      send_frame(32'h1234_5678, 1'b0, rd);
      read_check(2'd1, 32'h0001_0001, "badchk_status");
      check("badchk_irq", {31'd0, ins_irq}, 32'h0);

      // Checksum disabled: fill, coincident pop/push, overflow
      bus_write(2'd2, 32'h3);
      send_frame(32'h1234_5678, 1'b0, rd);
      for (int unsigned k = 1; k <= 7; k++) send_frame(k, 1'b0, rd);
      read_check(2'd1, 32'h0001_0802, "full_status");
      check("full_irq", {31'd0, ins_irq}, 32'h1);
      send_frame(32'h8, 1'b1, rd);
      check("poppush_data", rd, 32'h1234_5678);
      read_check(2'd1, 32'h0001_0802, "poppush_status");
      send_frame(32'h9, 1'b0, rd);
      read_check(2'd1, 32'h0001_0806, "ovf_status");
      for (int unsigned k = 1; k <= 8; k++)
         read_check(2'd0, k, $sformatf("order_%0d", k));
      read_check(2'd1, 32'h0001_0005, "drained_status");
      check("drained_irq", {31'd0, ins_irq}, 32'h0);
      bus_write(2'd3, 32'h2);
      read_check(2'd1, 32'h0001_0001, "clr_ovf");
      bus_write(2'd3, 32'h4);
      read_check(2'd1, 32'h0000_0001, "clr_err");

      // Frame followed by a repeat frame
      send_frame(32'h0000_00A5, 1'b0, rd);
      send_repeat();
`ifdef IR_RX_REPEAT_EN
      read_check(2'd1, 32'h0000_0200, "rpt_status");
      read_check(2'd0, 32'h0000_00A5, "rpt_first");
      read_check(2'd1, 32'h0000_0108, "rpt_flag");
`else
      read_check(2'd1, 32'h0000_0100, "rpt_status");
`endif

      // Truncated frame times out without pushing
      ir_hold(1'b0, 803);
      ir_hold(1'b1, 403);
      send_bits(32'hFFFF_0000, 16);
      ir_hold(1'b0, 43);
      ir_hold(1'b1, 100);
      check("trunc_busy", {31'd0, coe_busy}, 32'h1);
      repeat (1300) @(negedge csi_clk);
      check("trunc_idle", {31'd0, coe_busy}, 32'h0);
`ifdef IR_RX_REPEAT_EN
      read_check(2'd1, 32'h0000_0108, "trunc_status");
`else
      read_check(2'd1, 32'h0000_0100, "trunc_status");
`endif
      read_check(2'd0, 32'h0000_00A5, "rpt_code");
      read_check(2'd1, 32'h0000_0001, "trunc_empty");

      // Async reset mid-frame, then a clean frame
      ir_hold(1'b0, 803);
      ir_hold(1'b1, 403);
      send_bits(32'h0000_00FF, 8);
      ir_hold(1'b0, 10);
      check("mid_busy", {31'd0, coe_busy}, 32'h1);
      #2 csi_reset_n = 1'b0;
      #1;
      check("arst_readdata", avs_readdata, 32'h0);
      check("arst_irq", {31'd0, ins_irq}, 32'h0);
      check("arst_busy", {31'd0, coe_busy}, 32'h0);
      coe_IRDA_RXD = 1'b1;
      repeat (3) @(negedge csi_clk);
      csi_reset_n = 1'b1;
      repeat (3) @(negedge csi_clk);
      read_check(2'd2, 32'h0000_0005, "arst_ctrl");
      read_check(2'd1, 32'h0000_0001, "arst_status");
      send_frame(32'h00FF_A25D, 1'b0, rd);
      read_check(2'd1, 32'h0000_0100, "post_status");
      read_check(2'd0, 32'h00FF_A25D, "post_data");
      read_check(2'd1, 32'h0000_0001, "post_empty");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
